axi_flash_cache: RTL and testbench

Read-only, direct-mapped, one-word-per-line cache between the instruction/data fetch side of the AXI mux and the flash read controller. Serves repeated flash reads in 2 cycles instead of a full quad-I/O flash transaction. Misses are forwarded downstream as single-beat AXI reads, and each returned word is filled into the cache. An optional sequential prefetch hides the latency of straight-line code.

---
 rtl/common_types_pkg.sv | 27 ++
 rtl/axi_bus_if.sv | 34 +++
 rtl/flash_cache_array.sv | 49 ++++
 rtl/axi_flash_cache.sv | 172 +++++++++++++++++
 tb/tb_axi_flash_cache.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/common_types_pkg.sv
// Shared types for the flash read path: word type, AXI ID width and the flash cache FSM encoding.
// The PF_* states are only present when FLASH_CACHE_PREFETCH_EN is defined.
package common_types_pkg;

   typedef logic [31:0] word_t;

   localparam int AXI_ID_W                  = 4;
   localparam int FLASH_CACHE_DEFAULT_LINES = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOOKUP  = 3'd1,
      MISS_AR = 3'd2,
      MISS_R  = 3'd3,
      RESP    = 3'd4
`ifdef FLASH_CACHE_PREFETCH_EN
      ,
      PF_AR   = 3'd5,
      PF_R    = 3'd6
`endif
   } flash_cache_state_t;

   function automatic word_t sat_inc(input word_t v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/axi_bus_if.sv
// Reduced AXI bus used between the CPU-side mux, the flash cache and the flash controller.
// Only the read channels and the write-channel responses the cache ties off are carried.
interface axi_bus_if #(parameter int ID_W = common_types_pkg::AXI_ID_W);

   logic                       arvalid;
   logic                       arready;
   common_types_pkg::word_t    araddr;
   logic [ID_W-1:0]            arid;

   logic                       rvalid;
   logic                       rready;
   common_types_pkg::word_t    rdata;
   logic [1:0]                 rresp;
   logic [ID_W-1:0]            rid;
   logic                       rlast;

   logic                       awready;
   logic                       wready;
   logic                       bvalid;
   logic [ID_W-1:0]            bid;
   logic [1:0]                 bresp;

   modport satellite_to_mux (
      input  arvalid, araddr, arid, rready,
      output arready, rvalid, rdata, rresp, rid, rlast,
      output awready, wready, bvalid, bid, bresp
   );

   modport controller_to_mux (
      output arvalid, araddr, arid, rready,
      input  arready, rvalid, rdata, rresp
   );

endinterface

// File: rtl/flash_cache_array.sv
// Direct-mapped line storage for the flash cache: valid/tag/data per line in flops,
// combinational read, one write port, flush clears every valid bit and overrides a write.
module flash_cache_array
   import common_types_pkg::*;
#(
   parameter int LINES = FLASH_CACHE_DEFAULT_LINES,
   parameter int TAG_W = 26
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [$clog2(LINES)-1:0] rd_index,
   output logic                     rd_valid,
   output logic [TAG_W-1:0]         rd_tag,
   output word_t                    rd_data,
   input  logic                     we,
   input  logic [$clog2(LINES)-1:0] wr_index,
   input  logic [TAG_W-1:0]         wr_tag,
   input  word_t                    wr_data
);

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tags [LINES];
   word_t            data [LINES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
      end else if (flush) begin
         valid <= '0;
      end else if (we) begin
         valid[wr_index] <= 1'b1;
      end
   end

   // Tag/data need no reset; a line is only ever consulted through its valid bit.
   always_ff @(posedge clk) begin
      if (we) begin
         tags[wr_index] <= wr_tag;
         data[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tags[rd_index];
   assign rd_data  = data[rd_index];

endmodule

// File: rtl/axi_flash_cache.sv
// Read-only direct-mapped one-word-per-line cache in front of the flash read controller.
// Define FLASH_CACHE_PREFETCH_EN to add a sequential next-word prefetch after each good miss.
module axi_flash_cache
   import common_types_pkg::*;
#(
   parameter int LINES = FLASH_CACHE_DEFAULT_LINES
)
(
   input  logic                        clk,
   input  logic                        rst,
   axi_bus_if.satellite_to_mux         abif_s,
   axi_bus_if.controller_to_mux        abif_m,
   input  logic                        flush,
   output logic [31:0]                 hit_count,
   output logic [31:0]                 miss_count
);

   localparam int IDX   = $clog2(LINES);
   localparam int TAG_W = 30 - IDX;

   flash_cache_state_t  state;
   logic [29:0]         word_addr;
   logic [AXI_ID_W-1:0] id_q;
   word_t               rdata_q;
   logic [1:0]          rresp_q;
   logic                rvalid_q;

   logic [IDX-1:0]      index;
   logic [TAG_W-1:0]    tag;
   logic                line_valid;
   logic [TAG_W-1:0]    line_tag;
   word_t               line_data;
   logic                hit;
   logic                fill;

`ifdef FLASH_CACHE_PREFETCH_EN
   logic                pf_pending;
`endif

   // word_addr always holds the address being worked on; during prefetch it is already address+4.
   assign index = word_addr[IDX-1:0];
   assign tag   = word_addr[29:IDX];
   assign hit   = line_valid && (line_tag == tag);

`ifdef FLASH_CACHE_PREFETCH_EN
   assign fill = ((state == MISS_R) || (state == PF_R)) && abif_m.rvalid && (abif_m.rresp == 2'b00);
`else
   assign fill = (state == MISS_R) && abif_m.rvalid && (abif_m.rresp == 2'b00);
`endif

   flash_cache_array #(
      .LINES (LINES),
      .TAG_W (TAG_W)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .rd_index (index),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .we       (fill),
      .wr_index (index),
      .wr_tag   (tag),
      .wr_data  (abif_m.rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         word_addr  <= '0;
         id_q       <= '0;
         rdata_q    <= '0;
         rresp_q    <= 2'b00;
         rvalid_q   <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
`ifdef FLASH_CACHE_PREFETCH_EN
         pf_pending <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (abif_s.arvalid) begin
                  word_addr <= abif_s.araddr[31:2];
                  id_q      <= abif_s.arid;
                  state     <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  rdata_q   <= line_data;
                  rresp_q   <= 2'b00;
                  hit_count <= sat_inc(hit_count);
                  state     <= RESP;
               end else begin
                  miss_count <= sat_inc(miss_count);
                  state      <= MISS_AR;
               end
            end
            MISS_AR: begin
               if (abif_m.arready) begin
                  state <= MISS_R;
               end
            end
            MISS_R: begin
               if (abif_m.rvalid) begin
                  rdata_q <= abif_m.rdata;
                  rresp_q <= abif_m.rresp;
                  state   <= RESP;
`ifdef FLASH_CACHE_PREFETCH_EN
                  if (abif_m.rresp == 2'b00) begin
                     word_addr  <= word_addr + 30'd1;
                     pf_pending <= 1'b1;
                  end
`endif
               end
            end
            // The upstream beat is registered: rvalid rises one edge after entering RESP.
            RESP: begin
               if (!rvalid_q) begin
                  rvalid_q <= 1'b1;
               end else if (abif_s.rready) begin
                  rvalid_q <= 1'b0;
`ifdef FLASH_CACHE_PREFETCH_EN
                  pf_pending <= 1'b0;
                  state      <= (pf_pending && !hit) ? PF_AR : IDLE;
`else
                  state      <= IDLE;
`endif
               end
            end
`ifdef FLASH_CACHE_PREFETCH_EN
            PF_AR: begin
               if (abif_m.arready) begin
                  state <= PF_R;
               end
            end
            PF_R: begin
               if (abif_m.rvalid) begin
                  state <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

   assign abif_s.arready = (state == IDLE);
   assign abif_s.rvalid  = rvalid_q;
   assign abif_s.rdata   = rdata_q;
   assign abif_s.rresp   = rresp_q;
   assign abif_s.rid     = id_q;
   assign abif_s.rlast   = 1'b1;
   assign abif_s.awready = 1'b0;
   assign abif_s.wready  = 1'b0;
   assign abif_s.bvalid  = 1'b0;
   assign abif_s.bid     = '0;
   assign abif_s.bresp   = 2'b00;

`ifdef FLASH_CACHE_PREFETCH_EN
   assign abif_m.arvalid = (state == MISS_AR) || (state == PF_AR);
   assign abif_m.rready  = (state == MISS_R)  || (state == PF_R);
`else
   assign abif_m.arvalid = (state == MISS_AR);
   assign abif_m.rready  = (state == MISS_R);
`endif
   assign abif_m.araddr  = {tag, index, 2'b00};
   assign abif_m.arid    = id_q;

endmodule

// File: tb/tb_axi_flash_cache.sv
// Scoreboard bench for axi_flash_cache: directed reads against a modelled flash controller,
// upstream beats and downstream AR addresses checked by independent monitors.
module tb_axi_flash_cache;
   import common_types_pkg::*;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic [3:0]  id;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   axi_bus_if s_bus ();
   axi_bus_if m_bus ();

   axi_flash_cache #(.LINES(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .abif_s     (s_bus),
      .abif_m     (m_bus),
      .flush      (flush),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   beat_t       exp_q[$];
   logic [31:0] exp_ar_q[$];
   int          compared   = 0;
   int          mismatched = 0;
   int          dn_latency = 20;
   logic [31:0] err_addr   = 32'hFFFF_FFF0;
   int          exp_hits   = 0;
   int          exp_misses = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic noteFailure(input string name, input logic [31:0] actual);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected nothing", name, actual);
   endtask

   // Flash contents: 0x100 is special, every other word is derived from its address.
   function automatic logic [31:0] flash_word(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
      return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   // Downstream flash controller model.
   initial begin
      logic [31:0] cur;
      int          guard;
      m_bus.arready = 1'b0;
      m_bus.rvalid  = 1'b0;
      m_bus.rdata   = '0;
      m_bus.rresp   = 2'b00;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && m_bus.arvalid) begin
            cur           = m_bus.araddr;
            m_bus.arready = 1'b1;
            @(posedge clk);
            #1;
            m_bus.arready = 1'b0;
            repeat (dn_latency) @(posedge clk);
            #1;
            m_bus.rvalid = 1'b1;
            m_bus.rdata  = flash_word(cur);
            m_bus.rresp  = (cur == err_addr) ? 2'b10 : 2'b00;
            guard = 0;
            @(negedge clk);
            while (!m_bus.rready && guard < 2000) begin
               guard++;
               @(negedge clk);
            end
            if (guard >= 2000) noteFailure("downstream_rready_timeout", cur);
            @(posedge clk);
            #1;
            m_bus.rvalid = 1'b0;
         end
      end
   end

   // Upstream R monitor.
   always @(negedge clk) begin
      beat_t e;
      if (!rst && s_bus.rvalid && s_bus.rready) begin
         if (exp_q.size() == 0) begin
            noteFailure("unexpected_upstream_beat", s_bus.rdata);
         end else begin
            e = exp_q.pop_front();
            checkOutput("rdata", s_bus.rdata, e.data);
            checkOutput("rresp", {30'b0, s_bus.rresp}, {30'b0, e.resp});
            checkOutput("rid",   {28'b0, s_bus.rid},   {28'b0, e.id});
            checkOutput("rlast", {31'b0, s_bus.rlast}, 32'd1);
         end
      end
   end

   // Downstream AR monitor.
   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst && m_bus.arvalid && m_bus.arready) begin
         if (exp_ar_q.size() == 0) begin
            noteFailure("unexpected_downstream_ar", m_bus.araddr);
         end else begin
            e = exp_ar_q.pop_front();
            checkOutput("downstream_araddr", m_bus.araddr, e);
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] id,
                                input logic [31:0] exp_data, input logic [1:0] exp_resp,
                                input int exp_lat, input int hold);
      int waited;
      int edges;
      exp_q.push_back({exp_data, exp_resp, id});
      s_bus.arvalid = 1'b1;
      s_bus.araddr  = addr;
      s_bus.arid    = id;
      waited = 0;
      @(negedge clk);
      while (!s_bus.arready && waited < 2000) begin
         waited++;
         @(negedge clk);
      end
      if (waited >= 2000) begin
         noteFailure("arready_timeout", addr);
         s_bus.arvalid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      s_bus.arvalid = 1'b0;
      s_bus.rready  = (hold == 0);
      edges = 0;
      @(negedge clk);
      while (!s_bus.rvalid && edges < 2000) begin
         edges++;
         @(negedge clk);
      end
      if (edges >= 2000) begin
         noteFailure("rvalid_timeout", addr);
         s_bus.rready = 1'b1;
         return;
      end
      if (exp_lat >= 0) checkOutput("hit_latency", edges, exp_lat);
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            checkOutput("hold_rvalid",  {31'b0, s_bus.rvalid},  32'd1);
            checkOutput("hold_rdata",   s_bus.rdata,            exp_data);
            checkOutput("hold_arready", {31'b0, s_bus.arready}, 32'd0);
            checkOutput("hold_awready", {31'b0, s_bus.awready}, 32'd0);
            checkOutput("hold_wready",  {31'b0, s_bus.wready},  32'd0);
            @(negedge clk);
         end
         @(posedge clk);
         #1;
         s_bus.rready = 1'b1;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_hit_count"},  hit_count,  exp_hits);
      checkOutput({tag, "_miss_count"}, miss_count, exp_misses);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst           = 1'b1;
      flush         = 1'b0;
      s_bus.arvalid = 1'b0;
      s_bus.araddr  = '0;
      s_bus.arid    = '0;
      s_bus.rready  = 1'b1;

      @(negedge clk);
      checkOutput("reset_arready",   {31'b0, s_bus.arready}, 32'd1);
      checkOutput("reset_rvalid",    {31'b0, s_bus.rvalid},  32'd0);
      checkOutput("reset_m_arvalid", {31'b0, m_bus.arvalid}, 32'd0);
      checkOutput("reset_m_rready",  {31'b0, m_bus.rready},  32'd0);
      checkOutput("reset_awready",   {31'b0, s_bus.awready}, 32'd0);
      checkOutput("reset_bvalid",    {31'b0, s_bus.bvalid},  32'd0);
      checkCounters("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] cold miss at 0x100");
      exp_ar_q.push_back(32'h0000_0100);
`ifdef FLASH_CACHE_PREFETCH_EN
      exp_ar_q.push_back(32'h0000_0104);
`endif
      applyStimulus(32'h0000_0100, 4'd3, 32'hDEAD_BEEF, 2'b00, -1, 0);
      exp_misses++;
      checkCounters("cold");
      dn_latency = 3;

      $display("[TB] hit at 0x102");
      applyStimulus(32'h0000_0102, 4'd5, 32'hDEAD_BEEF, 2'b00, 2, 0);
      exp_hits++;
      checkCounters("hit");

      $display("[TB] alias 0x140 replaces index 0");
      exp_ar_q.push_back(32'h0000_0140);
`ifdef FLASH_CACHE_PREFETCH_EN
      exp_ar_q.push_back(32'h0000_0144);
`endif
      applyStimulus(32'h0000_0140, 4'd6, 32'hA4E5_0140, 2'b00, -1, 0);
      exp_misses++;
      exp_ar_q.push_back(32'h0000_0100);
`ifdef FLASH_CACHE_PREFETCH_EN
      exp_ar_q.push_back(32'h0000_0104);
`endif
      applyStimulus(32'h0000_0100, 4'd7, 32'hDEAD_BEEF, 2'b00, -1, 0);
      exp_misses++;
      applyStimulus(32'h0000_0100, 4'd8, 32'hDEAD_BEEF, 2'b00, 2, 0);
      exp_hits++;
      checkCounters("alias");

      $display("[TB] flush then re-read 0x100");
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      exp_ar_q.push_back(32'h0000_0100);
`ifdef FLASH_CACHE_PREFETCH_EN
      exp_ar_q.push_back(32'h0000_0104);
`endif
      applyStimulus(32'h0000_0100, 4'd9, 32'hDEAD_BEEF, 2'b00, -1, 0);
      exp_misses++;
      checkCounters("flush");

      $display("[TB] downstream error at 0x180");
      err_addr = 32'h0000_0180;
      exp_ar_q.push_back(32'h0000_0180);
      applyStimulus(32'h0000_0180, 4'd10, 32'hA425_0180, 2'b10, -1, 0);
      exp_misses++;
      exp_ar_q.push_back(32'h0000_0180);
      applyStimulus(32'h0000_0180, 4'd11, 32'hA425_0180, 2'b10, -1, 0);
      exp_misses++;
      checkCounters("error");

      $display("[TB] upstream backpressure on a hit");
      applyStimulus(32'h0000_0100, 4'd12, 32'hDEAD_BEEF, 2'b00, 2, 5);
      exp_hits++;
      checkCounters("hold");

      $display("[TB] sequential reads 0x200 / 0x204");
      exp_ar_q.push_back(32'h0000_0200);
      exp_ar_q.push_back(32'h0000_0204);
      applyStimulus(32'h0000_0200, 4'd1, 32'hA7A5_0200, 2'b00, -1, 0);
      exp_misses++;
`ifdef FLASH_CACHE_PREFETCH_EN
      applyStimulus(32'h0000_0204, 4'd2, 32'hA7A1_0204, 2'b00, 2, 0);
      exp_hits++;
`else
      applyStimulus(32'h0000_0204, 4'd2, 32'hA7A1_0204, 2'b00, -1, 0);
      exp_misses++;
`endif
      checkCounters("sequential");

      repeat (50) @(posedge clk);
      #1;
      checkOutput("pending_upstream_beats", exp_q.size(), 32'd0);
      checkOutput("pending_downstream_ars", exp_ar_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
